// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand loader.
// Holds the command byte encodings, the word width and the loader state enum.
package alu_pkg;
  localparam int WORD_W = 64;

  localparam logic [7:0] CMD_LOAD_PRIMARY   = 8'hA0;
  localparam logic [7:0] CMD_LOAD_SECONDARY = 8'hA1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2
  } load_state_e;
endpackage

// File: rtl/operand_loader_if.sv
// Host byte stream and ALU writeback signals of the operand loader.
// The master side is the host/ALU; the slave side is the loader.
interface operand_loader_if;
  import alu_pkg::*;

  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic [WORD_W-1:0] wb_data_i;
  logic              wb_valid_i;
  logic              wb_select_i;

  modport master (
    output byte_i, byte_valid_i, wb_data_i, wb_valid_i, wb_select_i,
    input  byte_ready_o
  );

  modport slave (
    input  byte_i, byte_valid_i, wb_data_i, wb_valid_i, wb_select_i,
    output byte_ready_o
  );
endinterface

// File: rtl/word_assembler.sv
// Little-endian 64-bit shift register with a 3-bit byte counter.
// last_o flags that the byte being shifted now is the eighth of the word.
module word_assembler
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      // new bytes enter at the top so the first byte ends up in bits 7:0
      word_d = {byte_i, word_q[WORD_W-1:8]};
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign last_o = (cnt_q == 3'd7);
endmodule

// File: rtl/operand_loader.sv
// Write-side front end for the primary/secondary ALU operand registers.
// Byte-stream loads commit whole words; writebacks land at any time, losing to a same-target commit.
module operand_loader
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  operand_loader_if.slave   bus,
  output logic [WORD_W-1:0] primary_register_o,
  output logic [WORD_W-1:0] secondary_register_o,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              error_o,
  output logic              wb_drop_o
);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  load_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic              target_q, target_d;
  logic [31:0]       idle_cnt_q, idle_cnt_d;
  logic              load_done_q, load_done_d;
  logic              error_q, error_d;
  logic              wb_drop_q, wb_drop_d;
  logic [WORD_W-1:0] prim_q, prim_d, sec_q, sec_d;

  logic              byte_fire, is_cmd, timeout, commit;
  logic              asm_clear, asm_shift, asm_last;
  logic [WORD_W-1:0] asm_word;

  assign byte_fire = bus.byte_valid_i && ready_q;
  assign is_cmd    = (bus.byte_i == CMD_LOAD_PRIMARY) || (bus.byte_i == CMD_LOAD_SECONDARY);
  assign commit    = (state_q == ST_COMMIT);
  assign timeout   = TIMEOUT_EN && (state_q == ST_DATA) && !byte_fire &&
                     (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  word_assembler u_asm (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (asm_clear),
    .shift_i (asm_shift),
    .byte_i  (bus.byte_i),
    .word_o  (asm_word),
    .last_o  (asm_last)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (byte_fire && is_cmd) state_d = ST_DATA;
      ST_DATA: begin
        if (byte_fire && asm_last) state_d = ST_COMMIT;
        else if (timeout)          state_d = ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    asm_clear   = ((state_q == ST_IDLE) && byte_fire && is_cmd) || timeout;
    asm_shift   = (state_q == ST_DATA) && byte_fire;
    error_d     = ((state_q == ST_IDLE) && byte_fire && !is_cmd) || timeout;
    load_done_d = commit;
    wb_drop_d   = commit && bus.wb_valid_i && (bus.wb_select_i == target_q);
    ready_d     = (state_d != ST_COMMIT);
    target_d    = target_q;
    if ((state_q == ST_IDLE) && byte_fire && is_cmd) target_d = bus.byte_i[0];
    idle_cnt_d  = '0;
    if (TIMEOUT_EN && (state_q == ST_DATA) && !byte_fire) idle_cnt_d = idle_cnt_q + 32'd1;
  end

  // commit overrides a writeback aimed at the same register
  always_comb begin
    prim_d = prim_q;
    sec_d  = sec_q;
    if (bus.wb_valid_i && !bus.wb_select_i) prim_d = bus.wb_data_i;
    if (bus.wb_valid_i &&  bus.wb_select_i) sec_d  = bus.wb_data_i;
    if (commit && !target_q) prim_d = asm_word;
    if (commit &&  target_q) sec_d  = asm_word;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q     <= 1'b0;
      target_q    <= 1'b0;
      idle_cnt_q  <= '0;
      load_done_q <= 1'b0;
      error_q     <= 1'b0;
      wb_drop_q   <= 1'b0;
      prim_q      <= '0;
      sec_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      target_q    <= target_d;
      idle_cnt_q  <= idle_cnt_d;
      load_done_q <= load_done_d;
      error_q     <= error_d;
      wb_drop_q   <= wb_drop_d;
      prim_q      <= prim_d;
      sec_q       <= sec_d;
    end
  end

  assign bus.byte_ready_o     = ready_q;
  assign primary_register_o   = prim_q;
  assign secondary_register_o = sec_q;
  assign busy_o               = (state_q != ST_IDLE);
  assign load_done_o          = load_done_q;
  assign error_o              = error_q;
  assign wb_drop_o            = wb_drop_q;
endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: expected pulse events are queued by the stimulus
// and popped by a monitor whenever the DUT raises load_done/error/wb_drop.
module tb_operand_loader;
  import alu_pkg::*;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  operand_loader_if bus();
  logic [63:0] primary_register_o, secondary_register_o;
  logic        busy_o, load_done_o, error_o, wb_drop_o;

  operand_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .bus                  (bus.slave),
    .primary_register_o   (primary_register_o),
    .secondary_register_o (secondary_register_o),
    .busy_o               (busy_o),
    .load_done_o          (load_done_o),
    .error_o              (error_o),
    .wb_drop_o            (wb_drop_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  pulses;   // {load_done, error, wb_drop}
    logic [63:0] prim;
    logic [63:0] sec;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input string name, input logic [2:0] p,
                           input logic [63:0] pr, input logic [63:0] se);
    exp_t e;
    e.name = name; e.pulses = p; e.prim = pr; e.sec = se;
    exp_q.push_back(e);
  endtask

  // monitor
  always @(negedge clk_i) begin
    if (load_done_o || error_o || wb_drop_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got %b, required none", {load_done_o, error_o, wb_drop_o});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_pulses"}, 64'({load_done_o, error_o, wb_drop_o}), 64'(e.pulses));
        check({e.name, "_prim"}, primary_register_o, e.prim);
        check({e.name, "_sec"}, secondary_register_o, e.sec);
      end
    end
  end

  task automatic put(input logic [7:0] b);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_prim"}, primary_register_o, 64'h0);
    check({tag, "_sec"}, secondary_register_o, 64'h0);
    check({tag, "_ready"}, 64'(bus.byte_ready_o), 64'h0);
    check({tag, "_busy"}, 64'(busy_o), 64'h0);
    check({tag, "_pulses"}, 64'({load_done_o, error_o, wb_drop_o}), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.byte_i = 8'h00; bus.byte_valid_i = 1'b0;
    bus.wb_data_i = '0; bus.wb_valid_i = 1'b0; bus.wb_select_i = 1'b0;

    idle(2);
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", 64'(bus.byte_ready_o), 64'h1);

    // full primary load
    expect_ev("load_primary", 3'b100, 64'h0807060504030201, 64'h0);
    put(CMD_LOAD_PRIMARY);
    for (int i = 1; i <= 8; i++) put(8'(i));
    check("commit_ready", 64'(bus.byte_ready_o), 64'h0);
    check("commit_busy", 64'(busy_o), 64'h1);
    check("commit_no_partial", primary_register_o, 64'h0);
    @(negedge clk_i);
    check("ready_after_commit", 64'(bus.byte_ready_o), 64'h1);
    idle(3);

    // bad command
    expect_ev("bad_cmd", 3'b010, 64'h0807060504030201, 64'h0);
    put(8'h55);
    check("bad_cmd_busy", 64'(busy_o), 64'h0);
    idle(3);

    // timeout after three data bytes
    expect_ev("timeout", 3'b010, 64'h0807060504030201, 64'h0);
    put(CMD_LOAD_SECONDARY);
    put(8'h11); put(8'h22); put(8'h33);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (error_o) begin n = i; break; end
    end
    check("timeout_cycles", 64'(n), 64'd16);
    check("timeout_busy", 64'(busy_o), 64'h0);
    idle(3);

    // commit and same-target writeback collide
    expect_ev("conflict_same", 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    put(CMD_LOAD_PRIMARY);
    for (int i = 0; i < 8; i++) put(8'hFF);
    bus.wb_valid_i = 1'b1; bus.wb_select_i = 1'b0; bus.wb_data_i = 64'h1234;
    @(negedge clk_i);
    bus.wb_valid_i = 1'b0;
    idle(3);

    // commit and other-target writeback both land
    expect_ev("conflict_other", 3'b100, 64'h1716151413121110, 64'h1234);
    put(CMD_LOAD_PRIMARY);
    for (int i = 0; i < 8; i++) put(8'(8'h10 + i));
    bus.wb_valid_i = 1'b1; bus.wb_select_i = 1'b1; bus.wb_data_i = 64'h1234;
    @(negedge clk_i);
    bus.wb_valid_i = 1'b0;
    idle(3);

    // plain writeback in IDLE
    bus.wb_valid_i = 1'b1; bus.wb_select_i = 1'b0; bus.wb_data_i = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk_i);
    bus.wb_valid_i = 1'b0;
    check("wb_idle_prim", primary_register_o, 64'hDEAD_BEEF_0000_0001);
    check("wb_idle_sec", secondary_register_o, 64'h1234);
    idle(2);

    // reset in the middle of a load
    put(CMD_LOAD_SECONDARY);
    for (int i = 1; i <= 5; i++) put(8'(8'hC0 + i));
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    expect_ev("load_after_reset", 3'b100, 64'h0, 64'hC8C7C6C5C4C3C2C1);
    put(CMD_LOAD_SECONDARY);
    for (int i = 1; i <= 8; i++) put(8'(8'hC0 + i));
    idle(4);

    check("events_outstanding", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
# operand_loader

Write-side front end for the ALU operand registers. It assembles 64-bit words from a host byte stream, or takes single-cycle ALU writebacks, and commits them into the primary and secondary operand registers. Those registers feed the ALU's passthrough/comparator selection stage. The block owns both registers; nothing else writes them.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65535: idle cycles allowed between data bytes before a load aborts. 0 disables the timeout.

Ports:
- `clk_i` input 1: single clock; every register is clocked on its rising edge.
- `rst_n_i` input 1: reset, asynchronous and active-low.
- `byte_i` input 8: host byte.
- `byte_valid_i` input 1: `byte_i` is valid.
- `byte_ready_o` output 1: loader accepts a byte. A transfer occurs when valid and ready are both high at a rising edge.
- `wb_data_i` input 64: ALU result to write back.
- `wb_valid_i` input 1: single-cycle writeback strobe.
- `wb_select_i` input 1: writeback target; 0 = primary, 1 = secondary.
- `primary_register_o` output 64: primary operand register.
- `secondary_register_o` output 64: secondary operand register.
- `busy_o` output 1: a byte load is in progress (state is not IDLE).
- `load_done_o` output 1: one-cycle pulse on the cycle after a byte-load commit.
- `error_o` output 1: one-cycle pulse on a bad command byte or a timeout.
- `wb_drop_o` output 1: one-cycle pulse when a writeback is discarded.

## Operation
- States: IDLE, DATA, COMMIT.
- IDLE, accepted byte:
  - 0xA0 selects primary; 0xA1 selects secondary. Latch the target, clear the byte counter, go to DATA.
  - Any other value: pulse `error_o`, stay in IDLE.
- DATA:
  - Each accepted byte is shifted into a 64-bit assembly register, little-endian: the first data byte becomes bits 7:0, the eighth becomes bits 63:56.
  - The byte counter is 3 bits. Acceptance of byte index 7 moves to COMMIT.
- COMMIT lasts exactly one cycle:
  - `byte_ready_o` = 0.
  - At the end of the cycle the whole assembled word is written to the target register. Partial words are never visible on the outputs.
  - Next state is IDLE; `load_done_o` pulses in the following cycle.
- Timeout:
  - In DATA, an idle counter increments on every cycle with no transfer and clears on each accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: pulse `error_o`, discard the assembly register, go to IDLE. The target register is unchanged.
- Writeback:
  - When `wb_valid_i` = 1, `wb_data_i` is written to the selected register at that edge, in any state.
- Conflict: writeback and COMMIT target the same register in the same cycle.
  - COMMIT wins and the writeback is discarded; `wb_drop_o` pulses in the next cycle.
  - If they target different registers, both writes occur.
- `byte_ready_o` = 1 in IDLE and DATA, 0 in COMMIT.

## Timing
- Reset values:
  - State IDLE.
  - Both registers, the assembly register, and all counters are 0.
  - `byte_ready_o` = 0 while `rst_n_i` is low, 1 from the first edge after release.
  - `busy_o`, `load_done_o`, `error_o`, `wb_drop_o` are 0.
- Latency:
  - Writeback: the new value is visible on the register output one cycle after the strobe edge.
  - Byte load: the word is visible on the register output the cycle after the COMMIT cycle. Minimum load is 10 cycles: command, 8 data bytes, COMMIT.
- Back-to-back: a new command byte is accepted the cycle after COMMIT.
- Reset mid-load: asserting `rst_n_i` aborts any state immediately, clears both registers, and produces no pulses.
- All pulse outputs are registered and last exactly one cycle.

## Structure
- Package `alu_pkg` holds:
  - `CMD_LOAD_PRIMARY` = 8'hA0 and `CMD_LOAD_SECONDARY` = 8'hA1.
  - The loader state enum (IDLE/DATA/COMMIT).
  - `WORD_W` = 64.
- Sub-module `word_assembler` contains the 64-bit little-endian shift register and the 3-bit byte counter, with clear/shift/last outputs. The FSM, timeout counter, and register write arbitration stay in the top.

## Test plan
- Send A0, then 01..08 with no gaps: `primary_register_o` = 64'h0807060504030201 one cycle after COMMIT, `load_done_o` pulses once, `secondary_register_o` stays 0.
- Send byte 0x55 in IDLE: `error_o` pulses one cycle, `busy_o` stays 0, both registers are unchanged.
- Send A1 and 3 data bytes, then idle with `TIMEOUT_CYCLES`=16: 16 cycles after the last byte `error_o` pulses, state returns to IDLE, the secondary register is unchanged.
- Send A0 and 8 bytes of 0xFF, and drive `wb_valid_i`=1, `wb_select_i`=0, `wb_data_i`=64'h1234 in the COMMIT cycle: primary = 64'hFFFFFFFFFFFFFFFF, `wb_drop_o` pulses. Repeat with `wb_select_i`=1: secondary = 64'h1234, no drop.
- Assert `rst_n_i` low after the 5th data byte: all outputs return to reset values immediately. Release reset, then run a full A1 load: secondary is correct.
